// File: rtl/sc_bcd_converter_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding, digit
// constants, the add-3 correction helper and seven-segment lookup codes.
package sc_bcd_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    // Active-low gfedcba patterns for the decimal digits.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // A working digit never exceeds 9 before correction, so +3 cannot carry out.
    function automatic logic [3:0] add3_correct(input logic [3:0] digit);
        return (digit >= ADD3_THRESHOLD) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/sc_bcd_sevenseg_decoder.sv
// One BCD digit to active-low gfedcba segments; non-decimal codes blank the digit.
module sc_bcd_sevenseg_decoder
    import sc_bcd_converter_pkg::*;
(
    input  logic [3:0] bcd_digit,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_BLANK;
        case (bcd_digit)
            4'd0:    segments = SEG_0;
            4'd1:    segments = SEG_1;
            4'd2:    segments = SEG_2;
            4'd3:    segments = SEG_3;
            4'd4:    segments = SEG_4;
            4'd5:    segments = SEG_5;
            4'd6:    segments = SEG_6;
            4'd7:    segments = SEG_7;
            4'd8:    segments = SEG_8;
            4'd9:    segments = SEG_9;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sc_bcd_converter.sv
// Sequential double-dabble converter: re-converts the bus whenever it differs
// from the last converted value. Optional SC_BCD_SEVENSEG_EN adds segment outputs.
module sc_bcd_converter
    import sc_bcd_converter_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 8,
    parameter int BCD_DIGITS    = 3
) (
    input  logic                            sc_bcd_converter_CLOCK_50,
    input  logic                            sc_bcd_converter_RESET_InHigh,
    input  logic [DATAWIDTH_BUS-1:0]        sc_bcd_converter_data_InBUS,
    output logic [BCD_DIGIT_W*BCD_DIGITS-1:0] sc_bcd_converter_bcd_OutBUS,
    output logic                            sc_bcd_converter_busy_Out,
`ifdef SC_BCD_SEVENSEG_EN
    output logic                            sc_bcd_converter_valid_OutPulse,
    output logic [7*BCD_DIGITS-1:0]         sc_bcd_converter_segments_OutBUS
`else
    output logic                            sc_bcd_converter_valid_OutPulse
`endif
);

    localparam int BCD_W = BCD_DIGIT_W * BCD_DIGITS;
    localparam int CNT_W = (DATAWIDTH_BUS > 1) ? $clog2(DATAWIDTH_BUS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATAWIDTH_BUS - 1);

    state_t                   state_q, state_d;
    logic [DATAWIDTH_BUS-1:0] last_q, last_d;
    logic [BCD_W-1:0]         bcd_work_q, bcd_work_d;
    logic [DATAWIDTH_BUS-1:0] bin_work_q, bin_work_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     busy_q, busy_d;
    logic                     valid_q, valid_d;
    logic [BCD_W-1:0]         bcd_out_q, bcd_out_d;
    logic [BCD_W-1:0]         bcd_corrected;

    always_comb begin
        bcd_corrected = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            bcd_corrected[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
                add3_correct(bcd_work_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        bcd_work_d = bcd_work_q;
        bin_work_d = bin_work_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        bcd_out_d  = bcd_out_q;

        case (state_q)
            ST_IDLE: begin
                if (sc_bcd_converter_data_InBUS != last_q) begin
                    last_d     = sc_bcd_converter_data_InBUS;
                    bcd_work_d = '0;
                    bin_work_d = sc_bcd_converter_data_InBUS;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                {bcd_work_d, bin_work_d} = {bcd_corrected, bin_work_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_out_d = bcd_work_q;
                valid_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sc_bcd_converter_CLOCK_50 or posedge sc_bcd_converter_RESET_InHigh) begin
        if (sc_bcd_converter_RESET_InHigh) begin
            state_q    <= ST_IDLE;
            last_q     <= '0;
            bcd_work_q <= '0;
            bin_work_q <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            bcd_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            bcd_work_q <= bcd_work_d;
            bin_work_q <= bin_work_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            bcd_out_q  <= bcd_out_d;
        end
    end

    assign sc_bcd_converter_bcd_OutBUS     = bcd_out_q;
    assign sc_bcd_converter_busy_Out       = busy_q;
    assign sc_bcd_converter_valid_OutPulse = valid_q;

`ifdef SC_BCD_SEVENSEG_EN
    // Decoding the registered result keeps the segments free of conversion glitches.
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_seg
        sc_bcd_sevenseg_decoder u_dec (
            .bcd_digit (bcd_out_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .segments  (sc_bcd_converter_segments_OutBUS[g*7 +: 7])
        );
    end
`endif

endmodule

// File: tb/tb_sc_bcd_converter.sv
// Directed bench for sc_bcd_converter: latency, boundary values, mid-conversion
// input changes, async reset abort and, when SC_BCD_SEVENSEG_EN is set, segments.
module tb_sc_bcd_converter;

    logic        clk;
    logic        rst;
    logic [7:0]  data;
    logic [11:0] bcd;
    logic        busy;
    logic        valid;
`ifdef SC_BCD_SEVENSEG_EN
    logic [20:0] segs;
`endif

    int testCount = 0;
    int failCount = 0;

    sc_bcd_converter #(.DATAWIDTH_BUS(8), .BCD_DIGITS(3)) dut (
        .sc_bcd_converter_CLOCK_50       (clk),
        .sc_bcd_converter_RESET_InHigh   (rst),
        .sc_bcd_converter_data_InBUS     (data),
        .sc_bcd_converter_bcd_OutBUS     (bcd),
        .sc_bcd_converter_busy_Out       (busy),
`ifdef SC_BCD_SEVENSEG_EN
        .sc_bcd_converter_valid_OutPulse (valid),
        .sc_bcd_converter_segments_OutBUS(segs)
`else
        .sc_bcd_converter_valid_OutPulse (valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] value);
        data = value;
    endtask

    // Counts edges until valid is seen; a timeout returns the budget.
    task automatic waitValid(input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!valid && cycles < budget);
    endtask

    logic [7:0]  sweepIn  [5] = '{8'd9, 8'd10, 8'd99, 8'd100, 8'd128};
    logic [11:0] sweepExp [5] = '{12'h009, 12'h010, 12'h099, 12'h100, 12'h128};

    initial begin
        int cycles;
        int validSeen;
        int busyLow;

        rst  = 1'b1;
        data = 8'd0;
        #12;
        rst = 1'b0;
        tick();

        // Idle with data matching the reset value of last
        validSeen = 0;
        busyLow   = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid) validSeen++;
            if (!busy) busyLow++;
        end
        checkOutput("idle_valid_pulses", validSeen, 0);
        checkOutput("idle_busy_low", busyLow, 20);
        checkOutput("idle_bcd", bcd, 12'h000);

        // 0 -> 255 latency profile
        applyStimulus(8'd255);
        tick();
        checkOutput("c255_busy_e0", busy, 1);
        checkOutput("c255_valid_e0", valid, 0);
        busyLow   = 0;
        validSeen = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (!busy) busyLow++;
            if (valid) validSeen++;
        end
        checkOutput("c255_busy_e1_8", busyLow, 0);
        checkOutput("c255_valid_e1_8", validSeen, 0);
        checkOutput("c255_bcd_stable", bcd, 12'h000);
        tick();
        checkOutput("c255_valid_e9", valid, 1);
        checkOutput("c255_busy_e9", busy, 0);
        checkOutput("c255_bcd", bcd, 12'h255);
        tick();
        checkOutput("c255_valid_e10", valid, 0);
        checkOutput("c255_bcd_hold", bcd, 12'h255);

        // Boundary sweep
        for (int i = 0; i < 5; i++) begin
            applyStimulus(sweepIn[i]);
            waitValid(30, cycles);
            checkOutput($sformatf("sweep%0d_latency", i), cycles, 10);
            checkOutput($sformatf("sweep%0d_bcd", i), bcd, sweepExp[i]);
        end

        // Input change during CONVERT
        applyStimulus(8'd37);
        tick();
        tick();
        tick();
        applyStimulus(8'd200);
        waitValid(30, cycles);
        checkOutput("mid_first_latency", cycles, 7);
        checkOutput("mid_first_bcd", bcd, 12'h037);
        waitValid(30, cycles);
        checkOutput("mid_second_latency", cycles, 10);
        checkOutput("mid_second_bcd", bcd, 12'h200);
        validSeen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid) validSeen++;
        end
        checkOutput("mid_extra_pulses", validSeen, 0);

        // Async reset aborting a conversion
        applyStimulus(8'd201);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("abort_busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_bcd_async", bcd, 12'h000);
        checkOutput("abort_busy_async", busy, 0);
        checkOutput("abort_valid_async", valid, 0);
`ifdef SC_BCD_SEVENSEG_EN
        checkOutput("seg_reset", segs, {7'b1000000, 7'b1000000, 7'b1000000});
`endif
        validSeen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (valid) validSeen++;
        end
        checkOutput("abort_valid_in_reset", validSeen, 0);
        rst = 1'b0;
        waitValid(30, cycles);
        checkOutput("abort_redo_latency", cycles, 10);
        checkOutput("abort_redo_bcd", bcd, 12'h201);

`ifdef SC_BCD_SEVENSEG_EN
        applyStimulus(8'd128);
        waitValid(30, cycles);
        checkOutput("seg128_bcd", bcd, 12'h128);
        checkOutput("seg128_d2", segs[20:14], 7'b1111001);
        checkOutput("seg128_d1", segs[13:7], 7'b0100100);
        checkOutput("seg128_d0", segs[6:0], 7'b0000000);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("seg_after_reset", segs, {7'b1000000, 7'b1000000, 7'b1000000});
        tick();
        rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
